// File: rtl/stuffer_pkg.sv
// Shared constants and helpers for the bit stuffer / destuffer pair.
package stuffer_pkg;

    // Run length of identical bits after which one complementary stuff bit follows.
    localparam int unsigned STUFF_LEN_DEFAULT = 5;

    // Width of one data byte on the serial link.
    localparam int unsigned BYTE_W = 8;

    // Classification of a receive-side bit sample.
    typedef enum logic [1:0] {
        SMP_NONE,
        SMP_DATA,
        SMP_STUFF_OK,
        SMP_STUFF_ERR
    } sample_kind_e;

    // Mid-bit sample point for a given clocks-per-bit count.
    function automatic logic [7:0] sample_point(input logic [7:0] baud);
        return 8'((9'(baud) + 9'd1) >> 1);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Multi-stage synchronizer for the serial line plus edge detection on the
// synchronized value. Runs every clock, independent of any enable.
module rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rxin,
    output logic rx_s,
    output logic rx_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev;

    // Shift the raw line through the synchronizer chain; idle line is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q[0] <= rxin;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            rx_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    // Final stage and a change flag against its previous-cycle value.
    always_comb begin
        rx_s    = sync_q[SYNC_STAGES-1];
        rx_edge = rx_s ^ rx_prev;
    end

endmodule

// File: rtl/destuffer.sv
// Serial bit destuffer: oversamples a stuffed line, removes stuff bits,
// flags stuff-rule violations and assembles LSB-first bytes.
module destuffer
    import stuffer_pkg::*;
#(
    parameter int unsigned STUFF_LEN   = STUFF_LEN_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              rxin,
    input  logic [7:0]        baudrate,
    output logic [BYTE_W-1:0] rxdata,
    output logic              rxvalid,
    output logic              stufferr
);

    localparam int unsigned RUN_W = $clog2(STUFF_LEN + 1);
    localparam int unsigned BIT_W = $clog2(BYTE_W);

    logic rx_s;
    logic rx_edge;

    logic [7:0]        cnt_q,     cnt_d;
    logic [RUN_W-1:0]  run_q,     run_d;
    logic              run_val_q, run_val_d;
    logic [BIT_W-1:0]  bitcnt_q,  bitcnt_d;
    logic [BYTE_W-1:0] shreg_q,   shreg_d;
    logic              byte_done;
    logic              do_sample;
    sample_kind_e      kind;

    rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .rxin   (rxin),
        .rx_s   (rx_s),
        .rx_edge(rx_edge)
    );

    // Baud counter, sample decision, run tracking and byte assembly.
    // The sample test uses the post-resync count, so an edge landing on the
    // stale sample point moves the sample rather than taking it early.
    always_comb begin
        cnt_d     = (cnt_q >= baudrate) ? 8'd1 : cnt_q + 8'd1;
        run_d     = run_q;
        run_val_d = run_val_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        kind      = SMP_NONE;

        if (rx_edge) begin
            cnt_d = 8'd1;
        end

        do_sample = (baudrate < 8'd2) || (cnt_d == sample_point(baudrate));

        if (do_sample) begin
            if (run_q == RUN_W'(STUFF_LEN)) begin
                kind = (rx_s == run_val_q) ? SMP_STUFF_ERR : SMP_STUFF_OK;
            end else begin
                kind = SMP_DATA;
            end
        end

        unique case (kind)
            SMP_DATA: begin
                if (rx_s == run_val_q) begin
                    run_d = run_q + RUN_W'(1);
                end else begin
                    run_d     = RUN_W'(1);
                    run_val_d = rx_s;
                end
                shreg_d   = {rx_s, shreg_q[BYTE_W-1:1]};
                bitcnt_d  = bitcnt_q + BIT_W'(1);
                byte_done = (bitcnt_q == BIT_W'(BYTE_W - 1));
            end
            SMP_STUFF_OK, SMP_STUFF_ERR: begin
                run_d     = RUN_W'(1);
                run_val_d = rx_s;
            end
            default: ;
        endcase
    end

    // State registers; enable low freezes everything and silences the pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 8'd1;
            run_q     <= '0;
            run_val_q <= 1'b1;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            rxdata    <= '0;
            rxvalid   <= 1'b0;
            stufferr  <= 1'b0;
        end else if (enable) begin
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            run_val_q <= run_val_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            if (byte_done) begin
                rxdata <= shreg_d;
            end
            rxvalid   <= byte_done;
            stufferr  <= (kind == SMP_STUFF_ERR);
        end else begin
            rxvalid   <= 1'b0;
            stufferr  <= 1'b0;
        end
    end

endmodule

// File: doc/destuffer.md
DESTUFFER -- requirements
Module: destuffer

Interface
REQ-001 SHALL have parameter STUFF_LEN, default 5: run length of identical bits after which one stuff bit follows.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flip-flop stages on rxin before use.
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  clock enable; low freezes all state.
REQ-006 SHALL have port rxin  input  1  stuffed serial line from the stuffer's txout.
REQ-007 SHALL have port baudrate  input  8  clocks per bit, unsigned.
REQ-008 SHALL have port rxdata  output  8  last completed destuffed byte.
REQ-009 SHALL have port rxvalid  output  1  one-cycle pulse: rxdata updated.
REQ-010 SHALL have port stufferr  output  1  one-cycle pulse: stuff-rule violation.

Function
REQ-011 SHALL pass rxin through SYNC_STAGES flops; the final stage is rx_s, and all logic uses only rx_s.
REQ-012 SHALL keep an 8-bit baud counter (range 1..baudrate) that increments each enabled cycle and wraps from baudrate to 1.
REQ-013 SHALL reload the baud counter to 1 on any enabled cycle where rx_s differs from its previous-cycle value (edge resync).
REQ-014 SHALL sample rx_s when counter == (baudrate+1)>>1; if baudrate < 2, it SHALL sample every enabled cycle.
REQ-015 SHALL track run length (0..STUFF_LEN) and run value of the sampled bits; a sample equal to the run value increments the run, and a different sample sets run=1 with the new value.
REQ-016 SHALL treat the sample following a run of STUFF_LEN as a stuff bit: discard it, set run=1 with that bit's value, and do not shift it into data.
REQ-017 SHALL treat a stuff-bit sample equal to the run value as a violation: stufferr=1 the next cycle, bit discarded, run=1.
REQ-018 SHALL shift each non-stuff sample into an 8-bit shift register LSB-first, with a 3-bit bit counter wrapping from 7 to 0.
REQ-019 SHALL, on the sample completing bit 7, copy the byte to rxdata and pulse rxvalid for exactly one cycle, one clock after the sample cycle.
REQ-020 SHALL keep rxdata stable between rxvalid pulses.
REQ-021 SHALL, while enable=0, hold the counter, run, shift register and rxdata, and force rxvalid=0 and stufferr=0; the sync flops keep running.
REQ-022 SHALL have no byte framing: byte boundaries are counted from reset release.
REQ-023 SHALL sample at the new counter value on a cycle where an edge and the sample point coincide, i.e. resync takes priority over a sample at the stale count.

Reset
REQ-024 SHALL, on rst_n=0, asynchronously clear: sync flops to 1 (idle line), counter=1, run=0, run value=1, bit counter=0, shift register=0, rxdata=8'h00, rxvalid=0, stufferr=0.
REQ-025 SHALL abandon a partial byte when reset asserts mid-byte, with no rxvalid pulse for it.

Structure
REQ-026 SHALL take STUFF_LEN default and the byte width constant from the shared package stuffer_pkg, which the stuffer also uses.
REQ-027 SHALL place the SYNC_STAGES synchronizer plus edge detect in one sub-module, rx_sync.

Verification
REQ-028 SHALL verify: baudrate=8, stuffer-driven byte 8'hA5 (no stuffing) -> one rxvalid, rxdata=8'hA5.
REQ-029 SHALL verify: baudrate=4, byte 8'hFF (stuff bit 0 inserted after 5 ones) -> rxdata=8'hFF, stufferr never asserted.
REQ-030 SHALL verify: six consecutive 1 bits driven raw at baudrate=4 -> stufferr pulses once, after the 6th sample.
REQ-031 SHALL verify: enable low for 20 cycles mid-byte at baudrate=8, line held constant -> byte resumes intact and rxdata is correct.
REQ-032 SHALL verify: rst_n low after 4 bits of 8'h3C -> outputs zero immediately; the next full byte 8'h81 decodes correctly.
REQ-033 SHALL verify: baudrate=1, bits driven every cycle, byte 8'h5A -> rxdata=8'h5A, rxvalid width exactly 1 cycle.
